wash_cycle_timer: RTL and testbench

//   Dual countdown timer that serves the washing machine controller FSM.
//   - Consumes the controller's T1Start/T2Start (level) and Mws/Lws (load size) outputs.
//   - Produces the T1Done/T2Done inputs the controller waits on.
//   - Durations are selected per load size; a PAUSE input (door open) freezes both timers.

---
 rtl/wash_cycle_timer.sv | 148 ++++++++++++++
 tb/tb_wash_cycle_timer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wash_cycle_timer.sv
// wash_cycle_timer: two independent countdown timers for the wash controller.
// Each timer loads a load-size dependent duration when its start level rises,
// counts ticks of its own prescaler, and holds Done until start drops.
//
// state   | meaning
// --------+-----------------------------------------------------
// ST_IDLE | waiting for start; counter cleared
// ST_RUN  | counting ticks down from the latched duration
// ST_DONE | duration elapsed; Done held until start is released

module wash_timer_chan #(
  parameter int CNT_W     = 16,
  parameter int PRESCALE  = 4,
  parameter int DUR_MED   = 3,
  parameter int DUR_LARGE = 5
) (
  input  logic             CLOCK,
  input  logic             nReset,
  input  logic             start,
  input  logic             mws,
  input  logic             lws,
  input  logic             pause,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [PRE_W-1:0] pre, pre_nx;
  logic [CNT_W-1:0] dur_sel;

  // Both load bits set is treated as a medium load.
  assign dur_sel = (lws && !mws) ? CNT_W'(DUR_LARGE) : CNT_W'(DUR_MED);

  // State, counter and prescaler registers.
  always_ff @(posedge CLOCK or negedge nReset) begin
    if (!nReset) begin
      state <= ST_IDLE;
      cnt_q <= '0;
      pre   <= '0;
    end else begin
      state <= state_nx;
      cnt_q <= cnt_nx;
      pre   <= pre_nx;
    end
  end

  // Next-state logic; abort takes priority over an expiring tick.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    pre_nx   = pre;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_RUN;
          cnt_nx   = dur_sel;
          pre_nx   = '0;
        end
      end
      ST_RUN: begin
        if (!start) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          pre_nx   = '0;
        end else if (cnt_q == '0) begin
          // zero-length duration expires on the first edge after load
          state_nx = ST_DONE;
          pre_nx   = '0;
        end else if (!pause) begin
          if (pre == PRE_LAST) begin
            pre_nx = '0;
            cnt_nx = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_nx = ST_DONE;
          end else begin
            pre_nx = pre + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!start) state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
        pre_nx   = '0;
      end
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign cnt  = cnt_q;

endmodule

module wash_cycle_timer #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 4,
  parameter int T1_MED   = 3,
  parameter int T1_LARGE = 5,
  parameter int T2_MED   = 2,
  parameter int T2_LARGE = 4
) (
  input  logic             CLOCK,
  input  logic             nReset,
  input  logic             T1Start,
  input  logic             T2Start,
  input  logic             Mws,
  input  logic             Lws,
  input  logic             PAUSE,
  output logic             T1Done,
  output logic             T2Done,
  output logic             T1Busy,
  output logic             T2Busy,
  output logic [CNT_W-1:0] REMAIN
);

  logic [CNT_W-1:0] t1_cnt, t2_cnt;

  wash_timer_chan #(
    .CNT_W(CNT_W), .PRESCALE(PRESCALE), .DUR_MED(T1_MED), .DUR_LARGE(T1_LARGE)
  ) u_t1 (
    .CLOCK(CLOCK), .nReset(nReset), .start(T1Start), .mws(Mws), .lws(Lws),
    .pause(PAUSE), .busy(T1Busy), .done(T1Done), .cnt(t1_cnt)
  );

  wash_timer_chan #(
    .CNT_W(CNT_W), .PRESCALE(PRESCALE), .DUR_MED(T2_MED), .DUR_LARGE(T2_LARGE)
  ) u_t2 (
    .CLOCK(CLOCK), .nReset(nReset), .start(T2Start), .mws(Mws), .lws(Lws),
    .pause(PAUSE), .busy(T2Busy), .done(T2Done), .cnt(t2_cnt)
  );

  // Remaining ticks: timer 1 has priority when both are counting.
  always_comb begin
    REMAIN = '0;
    if (T1Busy)      REMAIN = t1_cnt;
    else if (T2Busy) REMAIN = t2_cnt;
  end

endmodule

// File: tb/tb_wash_cycle_timer.sv
// tb_wash_cycle_timer: directed scenarios plus random stimulus against a
// cycle-budget reference model of the two wash timers.
`timescale 1ns/1ps
module tb_wash_cycle_timer;

  localparam int P = 4;
  localparam int DUR1 [2] = '{3, 5};   // med, large
  localparam int DUR2 [2] = '{2, 4};

  logic        CLOCK = 1'b0;
  logic        nReset = 1'b0;
  logic        T1Start = 1'b0, T2Start = 1'b0, Mws = 1'b0, Lws = 1'b0, PAUSE = 1'b0;
  logic        T1Done, T2Done, T1Busy, T2Busy;
  logic [15:0] REMAIN;

  int n_chk = 0;
  int n_bad = 0;

  wash_cycle_timer dut (
    .CLOCK(CLOCK), .nReset(nReset), .T1Start(T1Start), .T2Start(T2Start),
    .Mws(Mws), .Lws(Lws), .PAUSE(PAUSE), .T1Done(T1Done), .T2Done(T2Done),
    .T1Busy(T1Busy), .T2Busy(T2Busy), .REMAIN(REMAIN)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model: each timer owes a budget of unpaused cycles
  // (duration * prescale); remaining ticks is that budget rounded up.
  int m_mode [2];   // 0 idle, 1 counting, 2 expired
  int m_left [2];   // unpaused cycles still owed

  always @(posedge CLOCK or negedge nReset) begin
    logic st [2];
    int   big;
    if (!nReset) begin
      for (int i = 0; i < 2; i++) begin m_mode[i] = 0; m_left[i] = 0; end
    end else begin
      st[0] = T1Start;
      st[1] = T2Start;
      big = (Lws && !Mws) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
        if (m_mode[i] == 0) begin
          if (st[i]) begin
            m_mode[i] = 1;
            m_left[i] = ((i == 0) ? DUR1[big] : DUR2[big]) * P;
          end
        end else if (m_mode[i] == 1) begin
          if (!st[i]) begin
            m_mode[i] = 0; m_left[i] = 0;
          end else if (m_left[i] == 0) begin
            m_mode[i] = 2;
          end else if (!PAUSE) begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) m_mode[i] = 2;
          end
        end else if (!st[i]) begin
          m_mode[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_model();
    int rem;
    rem = (m_mode[0] == 1) ? (m_left[0] + P - 1) / P :
          (m_mode[1] == 1) ? (m_left[1] + P - 1) / P : 0;
    chk("m_t1busy", int'(T1Busy), int'(m_mode[0] == 1));
    chk("m_t1done", int'(T1Done), int'(m_mode[0] == 2));
    chk("m_t2busy", int'(T2Busy), int'(m_mode[1] == 1));
    chk("m_t2done", int'(T2Done), int'(m_mode[1] == 2));
    chk("m_remain", int'(REMAIN), rem);
  endtask

  // One clock edge, sampled 1ns later against the model.
  task automatic cyc();
    @(posedge CLOCK);
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    T1Start = 0; T2Start = 0; PAUSE = 0; Mws = 0; Lws = 0;
    nReset = 0;
    @(negedge CLOCK);
    nReset = 1;
    @(negedge CLOCK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with inputs toggling
    nReset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK);
      T1Start = i[0]; T2Start = ~i[0]; PAUSE = i[1]; Mws = 1;
      #1;
      chk("rst_busy", int'(T1Busy | T2Busy), 0);
      chk("rst_done", int'(T1Done | T2Done), 0);
      chk("rst_remain", int'(REMAIN), 0);
    end
    @(negedge CLOCK);
    T1Start = 0; T2Start = 0; PAUSE = 0;
    nReset = 1;
    cyc(); cyc();
    chk("post_rst", int'({T1Busy, T2Busy, T1Done, T2Done}), 0);

    // 2: medium T1 expires after 12 edges, holds, clears on release
    Mws = 1; T1Start = 1;
    cyc();
    chk("t2_busy", int'(T1Busy), 1);
    chk("t2_rem", int'(REMAIN), 3);
    repeat (11) cyc();
    chk("t2_done11", int'(T1Done), 0);
    cyc();
    chk("t2_done12", int'(T1Done), 1);
    repeat (3) cyc();
    chk("t2_held", int'(T1Done), 1);
    T1Start = 0;
    cyc();
    chk("t2_clear", int'(T1Done), 0);

    // 3: large T2 with load bits flipped mid-run
    do_reset();
    Lws = 1; T2Start = 1;
    cyc();
    repeat (5) cyc();
    Lws = 0; Mws = 1;
    repeat (10) cyc();
    chk("t3_done15", int'(T2Done), 0);
    cyc();
    chk("t3_done16", int'(T2Done), 1);

    // 4: five paused cycles delay expiry to edge 17
    do_reset();
    Mws = 1; T1Start = 1;
    cyc();
    repeat (4) cyc();
    PAUSE = 1;
    repeat (5) cyc();
    chk("t4_frozen", int'(REMAIN), 2);
    PAUSE = 0;
    repeat (7) cyc();
    chk("t4_done16", int'(T1Done), 0);
    cyc();
    chk("t4_done17", int'(T1Done), 1);

    // 5a: abort then full restart
    do_reset();
    Mws = 1; T1Start = 1;
    cyc();
    repeat (6) cyc();
    T1Start = 0;
    cyc();
    chk("t5_abort_busy", int'(T1Busy), 0);
    chk("t5_abort_done", int'(T1Done), 0);
    cyc();
    T1Start = 1;
    cyc();
    repeat (11) cyc();
    chk("t5_restart11", int'(T1Done), 0);
    cyc();
    chk("t5_restart12", int'(T1Done), 1);

    // 5b: both timers together
    do_reset();
    Mws = 1; T1Start = 1; T2Start = 1;
    cyc();
    repeat (7) cyc();
    chk("t5_t2_7", int'(T2Done), 0);
    cyc();
    chk("t5_t2_8", int'(T2Done), 1);
    chk("t5_t1_8", int'(T1Done), 0);
    chk("t5_rem_8", int'(REMAIN), 1);
    repeat (4) cyc();
    chk("t5_t1_12", int'(T1Done), 1);

    // 6: reset pulse mid-run, start held through it
    do_reset();
    Mws = 1; T1Start = 1;
    cyc();
    repeat (7) cyc();
    @(negedge CLOCK);
    nReset = 0;
    #1;
    chk("t6_busy", int'(T1Busy), 0);
    chk("t6_remain", int'(REMAIN), 0);
    @(negedge CLOCK);
    nReset = 1;
    cyc();
    repeat (11) cyc();
    chk("t6_done11", int'(T1Done), 0);
    cyc();
    chk("t6_done12", int'(T1Done), 1);

    // random: starts mostly held, occasional drops, pauses, load changes, resets
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 24) == 0) T1Start = ~T1Start;
      if ($urandom_range(0, 24) == 0) T2Start = ~T2Start;
      PAUSE = ($urandom_range(0, 5) == 0);
      Mws = $urandom_range(0, 1);
      Lws = $urandom_range(0, 1);
      if ($urandom_range(0, 399) == 0) begin
        nReset = 0;
        #1;
        chk_model();
        #2;
        nReset = 1;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
